cwc_capture_core: RTL and testbench

//  Parametrised capture engine for the ChipWatcher debug path: packed probe bus, programmable masked trigger,
//  pre-trigger window, circular sample RAM and a valid/ready readout stream.

---
 rtl/cwc_pkg.sv | 21 ++
 rtl/cwc_sdp_ram.sv | 29 ++
 rtl/cwc_capture_core.sv | 202 ++++++++++++++++++++
 tb/tb_cwc_capture_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cwc_pkg.sv
// Shared types for the ChipWatcher capture engine: FSM states, trigger modes, width limit.
package cwc_pkg;

    localparam int CWC_MAX_DATA_W = 1024;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        READ = 3'd4
    } cwc_state_e;

    typedef enum logic [1:0] {
        TRIG_LEVEL    = 2'd0,
        TRIG_EDGE     = 2'd1,
        TRIG_MISMATCH = 2'd2,
        TRIG_FORCE    = 2'd3
    } cwc_trig_mode_e;

endpackage

// File: rtl/cwc_sdp_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no array reset.
module cwc_sdp_ram
    import cwc_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port, one cycle latency
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/cwc_capture_core.sv
// ChipWatcher capture core: probe pipe, masked trigger, pre/post window capture into a
// circular RAM, and a valid/ready readout with an output register plus one-entry skid.
module cwc_capture_core
    import cwc_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int INPUT_PIPE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] probe_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic [2:0]        state_o,
    output logic [ADDR_W-1:0] trig_addr_o
);

    cwc_state_e        state_q, state_d;
    cwc_trig_mode_e    mode_q;
    logic [DATA_W-1:0] mask_q, value_q, probe_p, ram_rdata;
    logic [ADDR_W-1:0] pretrig_q, post_len, wr_ptr, pre_cnt, post_cnt, raddr;
    logic [ADDR_W:0]   rd_cnt;
    logic              match, match_q, hit, wr_en, arm_go, pop, rd_issue;
    logic              rd_vld_p1, rd_last_p1, skid_vld, skid_last;
    logic [DATA_W-1:0] skid_data;
    logic [1:0]        occ;

    // ---- probe pipe: trigger and storage see the same delayed sample
    if (INPUT_PIPE == 0) begin : g_nopipe
        assign probe_p = probe_i;
    end else begin : g_pipe
        logic [DATA_W-1:0] pipe_q [INPUT_PIPE];
        // Shift the probe through INPUT_PIPE register stages
        always_ff @(posedge clk) begin
            pipe_q[0] <= probe_i;
            for (int i = 1; i < INPUT_PIPE; i++) pipe_q[i] <= pipe_q[i-1];
        end
        assign probe_p = pipe_q[INPUT_PIPE-1];
    end

    // ---- trigger compare
    assign arm_go   = (state_q == IDLE) && arm_i && !abort_i;
    assign match    = ((probe_p & mask_q) == (value_q & mask_q));
    assign post_len = ~pretrig_q;   // DEPTH-1-pretrig, DEPTH being a power of two

    // Select the trigger condition for the latched mode
    always_comb begin
        hit = 1'b0;
        case (mode_q)
            TRIG_LEVEL:    hit = match;
            TRIG_EDGE:     hit = match & ~match_q;
            TRIG_MISMATCH: hit = ~match;
            TRIG_FORCE:    hit = 1'b1;
            default:       hit = 1'b0;
        endcase
    end

    // ---- FSM and write pointers
    // Next-state and write enable; abort overrides everything
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: if (arm_i) state_d = (pretrig_i == '0) ? WAIT : PRE;
            PRE: begin
                wr_en = 1'b1;
                if (pre_cnt == pretrig_q - ADDR_W'(1)) state_d = WAIT;
            end
            WAIT: begin
                wr_en = 1'b1;
                if (hit) state_d = (pretrig_q == '1) ? READ : POST;
            end
            POST: begin
                wr_en = 1'b1;
                if (post_cnt == post_len - ADDR_W'(1)) state_d = READ;
            end
            READ: if (pop && rd_last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
    end

    // State register, capture counters and latched trigger control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= TRIG_LEVEL;
            pretrig_q   <= '0;
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            match_q     <= 1'b0;
            trig_addr_o <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match;
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (state_q == PRE) pre_cnt <= pre_cnt + ADDR_W'(1);
            if (state_q == POST) post_cnt <= post_cnt + ADDR_W'(1);
            if (state_q == WAIT && hit) begin
                trig_addr_o <= wr_ptr;
                post_cnt    <= '0;
            end
            if (arm_go) begin
                mode_q    <= cwc_trig_mode_e'(trig_mode_i);
                pretrig_q <= pretrig_i;
                wr_ptr    <= '0;
                pre_cnt   <= '0;
                post_cnt  <= '0;
                match_q   <= 1'b0;
            end
        end
    end

    // Latch mask and compare value on arm
    always_ff @(posedge clk) begin
        if (arm_go) begin
            mask_q  <= trig_mask_i;
            value_q <= trig_value_i;
        end
    end

    assign state_o = state_q;

    // ---- sample RAM
    assign raddr = wr_ptr + rd_cnt[ADDR_W-1:0];

    cwc_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (probe_p),
        .re    (rd_issue),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // ---- readout: issue a read only if its data will have a free slot when it lands
    assign pop      = rd_valid_o & rd_ready_i;
    assign occ      = 2'(rd_valid_o) + 2'(skid_vld) + 2'(rd_vld_p1) - 2'(pop);
    assign rd_issue = (state_q == READ) && !abort_i && !rd_cnt[ADDR_W] && (occ <= 2'd1);

    // Read issue tracking, output register and skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt     <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_last_o  <= 1'b0;
            skid_vld   <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (abort_i || state_q != READ) begin
            rd_cnt     <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            skid_vld   <= 1'b0;
        end else begin
            rd_vld_p1  <= rd_issue;
            rd_last_p1 <= rd_issue && (rd_cnt[ADDR_W-1:0] == '1);
            if (rd_issue) rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
            if (pop || !rd_valid_o) begin
                if (skid_vld) begin
                    rd_valid_o <= 1'b1;
                    rd_data_o  <= skid_data;
                    rd_last_o  <= skid_last;
                    skid_vld   <= rd_vld_p1;
                    if (rd_vld_p1) begin
                        skid_data <= ram_rdata;
                        skid_last <= rd_last_p1;
                    end
                end else if (rd_vld_p1) begin
                    rd_valid_o <= 1'b1;
                    rd_data_o  <= ram_rdata;
                    rd_last_o  <= rd_last_p1;
                end else begin
                    rd_valid_o <= 1'b0;
                    rd_last_o  <= 1'b0;
                end
            end else if (rd_vld_p1) begin
                skid_vld  <= 1'b1;
                skid_data <= ram_rdata;
                skid_last <= rd_last_p1;
            end
        end
    end

endmodule

// File: tb/tb_cwc_capture_core.sv
// Bench for cwc_capture_core at DEPTH=16, DATA_W=8 with a counting probe.
module tb_cwc_capture_core;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int S_IDLE = 0, S_PRE = 1, S_WAIT = 2, S_POST = 3, S_READ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] probe_i = '0;
    logic              arm_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [1:0]        trig_mode_i = '0;
    logic [DATA_W-1:0] trig_mask_i = '0;
    logic [DATA_W-1:0] trig_value_i = '0;
    logic [ADDR_W-1:0] pretrig_i = '0;
    logic              rd_valid_o;
    logic              rd_ready_i = 1'b1;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_last_o;
    logic [2:0]        state_o;
    logic [ADDR_W-1:0] trig_addr_o;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    pc = 0;
    bit    rand_ready = 1'b0;

    cwc_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .INPUT_PIPE(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .probe_i      (probe_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_mode_i  (trig_mode_i),
        .trig_mask_i  (trig_mask_i),
        .trig_value_i (trig_value_i),
        .pretrig_i    (pretrig_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_last_o    (rd_last_o),
        .state_o      (state_o),
        .trig_addr_o  (trig_addr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout state=%0d", name, state_o);
    endtask

    // Advance to the next falling edge and drive the per-cycle inputs.
    task automatic tick();
        @(negedge clk);
        arm_i      = 1'b0;
        abort_i    = 1'b0;
        probe_i    = 8'(pc);
        pc++;
        rd_ready_i = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    endtask

    // Model: probe sample j has value j mod 256; sample 0 follows the arm edge.
    function automatic bit mt(input int j, input logic [7:0] mask, input logic [7:0] value);
        logic [7:0] s;
        s = 8'(j);
        return (s & mask) == (value & mask);
    endfunction

    // First sample index at or after the pre-trigger window satisfying the trigger mode.
    function automatic int model_trig(input int mode, input logic [7:0] mask,
                                      input logic [7:0] value, input int pre);
        for (int k = pre; k < 256; k++) begin
            bit m, mp;
            m  = mt(k, mask, value);
            mp = (k > 0) ? mt(k - 1, mask, value) : 1'b0;
            case (mode)
                0: if (m) return k;
                1: if (m && !mp) return k;
                2: if (!m) return k;
                default: return k;
            endcase
        end
        return -1;
    endfunction

    // Expected stream: samples k-pre .. k-pre+DEPTH-1, last flag on the final one.
    task automatic load_model(input int k, input int pre);
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            b.d = 8'(k - pre + i);
            b.l = (i == DEPTH - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_arm(input int mode, input logic [7:0] mask, input logic [7:0] value,
                          input int pre);
        tick();
        trig_mode_i  = 2'(mode);
        trig_mask_i  = mask;
        trig_value_i = value;
        pretrig_i    = 4'(pre);
        arm_i        = 1'b1;
        pc           = 0;
        tick();
    endtask

    task automatic run_capture(input string name, input int mode, input logic [7:0] mask,
                               input logic [7:0] value, input int pre, input int k_lit,
                               input int first_lit, input int ta_lit,
                               input bit arm_in_read, input bit no_post);
        int k;
        bit done, saw_post, rearmed, rearm_chk;
        k = model_trig(mode, mask, value, pre);
        chk({name, "_model_k"}, k, k_lit);
        load_model(k, pre);
        chk({name, "_model_first"}, exp_q[0].d, first_lit);
        do_arm(mode, mask, value, pre);
        #1 chk({name, "_state_after_arm"}, state_o, (pre == 0) ? S_WAIT : S_PRE);
        done = 0; saw_post = 0; rearmed = 0; rearm_chk = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            #2;
            if (rearm_chk) begin
                chk({name, "_arm_in_read_ignored"}, state_o, S_READ);
                rearm_chk = 0;
            end
            if (state_o == S_POST) saw_post = 1;
            if (arm_in_read && !rearmed && state_o == S_READ) begin
                arm_i     = 1'b1;
                rearmed   = 1;
                rearm_chk = 1;
            end
            if (exp_q.size() == 0 && state_o == S_IDLE) done = 1;
        end
        if (!done) fail_timeout(name);
        chk({name, "_trig_addr"}, trig_addr_o, ta_lit);
        if (no_post) chk({name, "_post_skipped"}, saw_post, 0);
        tick();
        #1 chk({name, "_valid_after_stream"}, rd_valid_o, 0);
    endtask

    // Compare process: checks every handshake against the model and hold under stall.
    initial begin : compare
        bit         stall;
        logic [7:0] hd;
        logic       hl;
        beat_t      e;
        stall = 0; hd = '0; hl = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("stall_valid", rd_valid_o, 1);
                    chk("stall_data", rd_data_o, hd);
                    chk("stall_last", rd_last_o, hl);
                end
                if (rd_valid_o && rd_ready_i && !abort_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat data=%0d expected=none", rd_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", rd_data_o, e.d);
                        chk("beat_last", rd_last_o, e.l);
                    end
                end
                stall = rd_valid_o && !rd_ready_i && !abort_i;
                hd    = rd_data_o;
                hl    = rd_last_o;
            end
        end
    end

    initial begin : stim
        bit got;
        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", state_o, S_IDLE);
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_last", rd_last_o, 0);
        chk("rst_data", rd_data_o, 0);
        chk("rst_trig_addr", trig_addr_o, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // T1..T4
        run_capture("t1", 0, 8'hFF, 8'd20, 4, 20, 16, 4, 0, 0);
        run_capture("t2", 1, 8'h01, 8'h01, 0, 1, 1, 1, 0, 0);
        run_capture("t3", 3, 8'h00, 8'h00, 15, 15, 0, 15, 0, 1);
        rand_ready = 1'b1;
        run_capture("t4", 0, 8'hFF, 8'd30, 2, 30, 28, 14, 0, 0);
        rand_ready = 1'b0;

        // T5: abort in WAIT
        do_arm(0, 8'hFF, 8'd200, 2);
        for (int c = 0; c < 8; c++) tick();
        #1 chk("t5_in_wait", state_o, S_WAIT);
        tick();
        abort_i = 1'b1;
        tick();
        #1;
        chk("t5_wait_abort_state", state_o, S_IDLE);
        chk("t5_wait_abort_valid", rd_valid_o, 0);

        // T5: abort in READ after five beats
        load_model(model_trig(0, 8'hFF, 8'd20, 4), 4);
        do_arm(0, 8'hFF, 8'd20, 4);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            #2;
            if (exp_q.size() == DEPTH - 5) got = 1;
        end
        if (!got) fail_timeout("t5_read_beats");
        tick();
        abort_i = 1'b1;
        exp_q.delete();
        tick();
        #1;
        chk("t5_read_abort_state", state_o, S_IDLE);
        chk("t5_read_abort_valid", rd_valid_o, 0);

        // arm and abort together
        tick();
        arm_i   = 1'b1;
        abort_i = 1'b1;
        tick();
        #1 chk("t5_arm_abort_state", state_o, S_IDLE);
        run_capture("t5b", 0, 8'hFF, 8'd20, 4, 20, 16, 4, 0, 0);

        // T6: reset pulse in POST
        load_model(model_trig(0, 8'hFF, 8'd20, 4), 4);
        do_arm(0, 8'hFF, 8'd20, 4);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            #2;
            if (state_o == S_POST) got = 1;
        end
        if (!got) fail_timeout("t6_reach_post");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state_o, S_IDLE);
        chk("t6_rst_valid", rd_valid_o, 0);
        chk("t6_rst_last", rd_last_o, 0);
        chk("t6_rst_data", rd_data_o, 0);
        chk("t6_rst_trig_addr", trig_addr_o, 0);
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        #1;
        chk("t6_idle_after_rst", state_o, S_IDLE);
        chk("t6_valid_after_rst", rd_valid_o, 0);
        run_capture("t6b", 0, 8'hFF, 8'd20, 4, 20, 16, 4, 1, 0);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
